// File: rtl/nco_sine_gen_pkg.sv
// Shared types and constants for the NCO sine source.
// Holds the quarter-wave table generator and dither LFSR constants.
package nco_pkg;

  localparam int GEN_WD_DEF   = 16;
  localparam int PHASE_WD_DEF = 24;
  localparam int LUT_AW_DEF   = 8;
  localparam int DIV_WD_DEF   = 12;

  // Fibonacci taps x^16+x^14+x^13+x^11+1 on a left-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  // Half-sample offset keeps every entry below the negation limit
  function automatic int qsin(
    input int k,
    input int aw,
    input int wd
  );
    real ang;
    real fs;
    real v;
    ang = 1.5707963267948966
        * (real'(k) + 0.5)
        / real'(1 << aw);
    fs  = real'((1 << (wd - 1)) - 1);
    v   = $sin(ang) * fs;
    return $rtoi(v + 0.5);
  endfunction

  function automatic logic lfsr_fb(
    input logic [15:0] s
  );
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/nco_sine_gen_if.sv
// Control and sample bus of the NCO sine source.
// master drives the controls, slave is the generator.
interface nco_sine_gen_if #(
  parameter int GEN_WD   = 16,
  parameter int PHASE_WD = 24,
  parameter int DIV_WD   = 12
);

  logic                en_i;
  logic [DIV_WD-1:0]   div_i;
  logic [PHASE_WD-1:0] ftw_i;
  logic                ftw_load_i;
  logic [GEN_WD-1:0]   amp_i;
  logic                phase_clr_i;
  logic [GEN_WD-1:0]   wave_o;
  logic                valid_o;
  logic [PHASE_WD-1:0] phase_o;

  modport master (
    output en_i,
    output div_i,
    output ftw_i,
    output ftw_load_i,
    output amp_i,
    output phase_clr_i,
    input  wave_o,
    input  valid_o,
    input  phase_o
  );

  modport slave (
    input  en_i,
    input  div_i,
    input  ftw_i,
    input  ftw_load_i,
    input  amp_i,
    input  phase_clr_i,
    output wave_o,
    output valid_o,
    output phase_o
  );

endinterface

// File: rtl/nco_sine_gen_qlut.sv
// Registered quarter-wave sine ROM, magnitude only.
// Contents are built at elaboration from nco_pkg::qsin.
module sine_qlut
  import nco_pkg::*;
#(
  parameter int LUT_AW = 8,
  parameter int MAG_WD = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [LUT_AW-1:0] i_addr,
  output logic [MAG_WD-1:0] o_mag
);

  localparam int DEPTH = 1 << LUT_AW;

  logic [MAG_WD-1:0] w_rom [DEPTH];
  logic [MAG_WD-1:0] r_mag;

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int V = qsin(k, LUT_AW, MAG_WD + 1);
    assign w_rom[k] = MAG_WD'(V);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mag <= '0;
    end else begin
      r_mag <= w_rom[i_addr];
    end
  end

  assign o_mag = r_mag;

endmodule

// File: rtl/nco_sine_gen.sv
// NCO sine source: divider, accumulator, fold, LUT, sign, scale.
// Define NCO_DITHER_EN to add LFSR phase dither ahead of the fold.
module nco_sine_gen
  import nco_pkg::*;
#(
  parameter int GEN_WD   = GEN_WD_DEF,
  parameter int PHASE_WD = PHASE_WD_DEF,
  parameter int LUT_AW   = LUT_AW_DEF,
  parameter int DIV_WD   = DIV_WD_DEF
) (
  input logic           clk_i,
  input logic           rst_ni,
  nco_sine_gen_if.slave bus
);

  localparam int PW = 2 * GEN_WD + 1;
  localparam int LO = PHASE_WD - LUT_AW - 2;

  logic [DIV_WD-1:0]        r_cnt;
  logic                     w_tick;
  logic [PHASE_WD-1:0]      r_phase;
  logic [PHASE_WD-1:0]      w_phase_nxt;
  logic [PHASE_WD-1:0]      r_ftw_act;
  logic [PHASE_WD-1:0]      r_ftw_pend;
  logic                     r_pend;
  logic [PHASE_WD-1:0]      w_fold;
  quad_e                    w_q;
  logic [LUT_AW-1:0]        w_idx;
  quad_e                    r_q1;
  logic [LUT_AW-1:0]        r_idx1;
  logic                     r_v1;
  logic [GEN_WD-2:0]        w_mag;
  quad_e                    r_q2;
  logic                     r_v2;
  logic signed [GEN_WD-1:0] w_s;
  logic signed [GEN_WD-1:0] r_s3;
  logic                     r_v3;
  logic signed [PW-1:0]     w_prod;
  logic [GEN_WD-1:0]        r_wave;
  logic                     r_valid;
  logic                     w_unused;

  assign w_tick = bus.en_i
               && (r_cnt >= bus.div_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else if (bus.en_i) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A load on a tick cycle defers the apply to the following tick
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ftw_pend <= '0;
      r_ftw_act  <= '0;
      r_pend     <= 1'b0;
    end else if (bus.ftw_load_i) begin
      r_ftw_pend <= bus.ftw_i;
      r_pend     <= 1'b1;
    end else if (w_tick && r_pend) begin
      r_ftw_act  <= r_ftw_pend;
      r_pend     <= 1'b0;
    end
  end

  always_comb begin
    w_phase_nxt = r_phase;
    if (bus.phase_clr_i) begin
      w_phase_nxt = '0;
    end else if (w_tick) begin
      w_phase_nxt = r_phase + r_ftw_act;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_phase <= '0;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

`ifdef NCO_DITHER_EN
  localparam int DITH_W = (LO < 16) ? LO : 16;

  logic [15:0]         r_lfsr;
  logic [PHASE_WD-1:0] w_dith;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_tick) begin
      r_lfsr <= {r_lfsr[14:0], lfsr_fb(r_lfsr)};
    end
  end

  always_comb begin
    w_dith = '0;
    for (int i = 0; i < DITH_W; i++) begin
      w_dith[i] = r_lfsr[i];
    end
  end

  assign w_fold = w_phase_nxt + w_dith;
`else
  assign w_fold = w_phase_nxt;
`endif

  assign w_q = quad_e'(w_fold[PHASE_WD-1 -: 2]);

  always_comb begin
    w_idx = w_fold[PHASE_WD-3 -: LUT_AW];
    unique case (w_q)
      Q1, Q3:  w_idx = ~w_fold[PHASE_WD-3 -: LUT_AW];
      default: w_idx = w_fold[PHASE_WD-3 -: LUT_AW];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q1   <= Q0;
      r_idx1 <= '0;
      r_v1   <= 1'b0;
    end else begin
      r_q1   <= w_q;
      r_idx1 <= w_idx;
      r_v1   <= w_tick;
    end
  end

  sine_qlut #(
    .LUT_AW (LUT_AW),
    .MAG_WD (GEN_WD - 1)
  ) u_qlut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_addr (r_idx1),
    .o_mag  (w_mag)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q2 <= Q0;
      r_v2 <= 1'b0;
    end else begin
      r_q2 <= r_q1;
      r_v2 <= r_v1;
    end
  end

  always_comb begin
    w_s = $signed({1'b0, w_mag});
    unique case (r_q2)
      Q2, Q3:  w_s = -$signed({1'b0, w_mag});
      default: w_s = $signed({1'b0, w_mag});
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s3 <= '0;
      r_v3 <= 1'b0;
    end else begin
      r_s3 <= w_s;
      r_v3 <= r_v2;
    end
  end

  // Taking the upper product half is the floor shift by GEN_WD
  assign w_prod = PW'(r_s3)
                * PW'($signed({1'b0, bus.amp_i}));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wave  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_v3;
      if (r_v3) begin
        r_wave <= w_prod[2*GEN_WD-1:GEN_WD];
      end
    end
  end

  assign w_unused = ^{w_fold[LO-1:0],
                      w_prod[PW-1],
                      w_prod[GEN_WD-1:0]};

  assign bus.wave_o  = r_wave;
  assign bus.valid_o = r_valid;
  assign bus.phase_o = r_phase;

endmodule

// File: tb/tb_nco_sine_gen.sv
// Directed and random bench for nco_sine_gen.
// Reference model works from phase arithmetic and a full-cycle sine.
module tb_nco_sine_gen;

  localparam int  GW = 16;
  localparam int  PW = 24;
  localparam int  AW = 8;
  localparam int  DW = 12;
  localparam int  SH = PW - AW - 2;
  localparam real PI = 3.14159265358979323846;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  nco_sine_gen_if #(
    .GEN_WD   (GW),
    .PHASE_WD (PW),
    .DIV_WD   (DW)
  ) bus ();

  nco_sine_gen #(
    .GEN_WD   (GW),
    .PHASE_WD (PW),
    .LUT_AW   (AW),
    .DIV_WD   (DW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          peak  = 0;
  logic [GW-1:0] m_wave = '0;

  logic [PW-1:0] m_phase = '0;
  logic [PW-1:0] m_act   = '0;
  logic [PW-1:0] m_pend  = '0;
  logic          m_flag  = 1'b0;
  int            m_cnt   = 0;
  logic [GW-1:0] m_amp   = '0;
  int            exp_due [64];
  int            exp_s   [64];

  logic          m_tick;
  logic [PW-1:0] m_np;

  // Signed sample of a full sine cycle sampled at bin centres
  function automatic int ref_s(input logic [PW-1:0] ph);
    int  pos;
    real fs;
    real x;
    pos = int'(ph >> SH);
    fs  = real'((1 << (GW - 1)) - 1);
    x   = fs * $sin(2.0 * PI * (real'(pos) + 0.5)
                    / real'(1 << (AW + 2)));
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic logic [GW-1:0] scale(
    input int s,
    input logic [GW-1:0] a
  );
    longint p;
    p = longint'(s) * longint'({1'b0, a});
    return GW'(p >>> GW);
  endfunction

  assign m_tick = bus.en_i
               && (m_cnt >= int'(bus.div_i));
  assign m_np = bus.phase_clr_i ? '0
              : (m_tick ? m_phase + m_act : m_phase);

  initial begin
    for (int i = 0; i < 64; i++) exp_due[i] = -1;
  end

  // In-flight samples are abandoned on reset by jumping the cycle index
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= '0;
      m_act   <= '0;
      m_pend  <= '0;
      m_flag  <= 1'b0;
      m_cnt   <= 0;
      cyc     <= cyc + 10;
    end else begin
      m_amp   <= bus.amp_i;
      m_phase <= m_np;
      cyc     <= cyc + 1;
      m_cnt   <= m_tick ? 0
               : (bus.en_i ? m_cnt + 1 : m_cnt);
      if (m_tick) begin
        exp_due[(cyc + 4) % 64] <= cyc + 4;
        exp_s[(cyc + 4) % 64]   <= ref_s(m_np);
      end
      if (bus.ftw_load_i) begin
        m_pend <= bus.ftw_i;
        m_flag <= 1'b1;
      end else if (m_tick && m_flag) begin
        m_act  <= m_pend;
        m_flag <= 1'b0;
      end
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (exp_due[cyc % 64] == cyc) begin
        m_wave = scale(exp_s[cyc % 64], m_amp);
        chk("valid_hi", bus.valid_o, 1);
      end else begin
        chk("valid_lo", bus.valid_o, 0);
      end
      chk("wave", bus.wave_o, m_wave);
      chk("phase", bus.phase_o, m_phase);
      if ($signed(bus.wave_o) > peak)
        peak = $signed(bus.wave_o);
    end
  endtask

  task automatic wait_cnt(input int v);
    int k;
    k = 0;
    while (m_cnt != v && k < 40) begin
      step(1);
      k++;
    end
    chk("cnt_reach", m_cnt, v);
  endtask

  task automatic load(input logic [PW-1:0] f);
    bus.ftw_i      = f;
    bus.ftw_load_i = 1'b1;
    step(1);
    bus.ftw_load_i = 1'b0;
  endtask

  initial begin
    bus.en_i        = 1'b0;
    bus.div_i       = '0;
    bus.ftw_i       = '0;
    bus.ftw_load_i  = 1'b0;
    bus.amp_i       = 16'hFFFF;
    bus.phase_clr_i = 1'b0;
    m_wave          = '0;

    step(3);
    chk("rst_wave", bus.wave_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_phase", bus.phase_o, 0);
    rst_n = 1'b1;

    bus.en_i = 1'b1;
    step(100);
    chk("idle_phase", bus.phase_o, 0);

    load(PW'(16384));
    bus.phase_clr_i = 1'b1;
    step(1);
    bus.phase_clr_i = 1'b0;
    peak = -32768;
    step(1024);
    chk("wrap_phase", bus.phase_o, 0);
    chk("peak", peak, 32766);

    bus.div_i = DW'(9);
    step(60);
    wait_cnt(7);
    bus.div_i = DW'(3);
    step(4);
    chk("div_lower", bus.valid_o, 1);

    bus.div_i = DW'(9);
    step(30);
    wait_cnt(4);
    load(PW'(32768));
    step(60);

    bus.div_i = '0;
    bus.amp_i = '0;
    step(20);
    chk("amp_zero", bus.wave_o, 0);
    bus.amp_i = 16'h8000;
    step(300);

    bus.amp_i       = 16'hFFFF;
    bus.phase_clr_i = 1'b1;
    step(1);
    bus.phase_clr_i = 1'b0;
    chk("clr_wins", bus.phase_o, 0);
    step(30);
    rst_n  = 1'b0;
    m_wave = '0;
    step(3);
    chk("mid_rst_valid", bus.valid_o, 0);
    chk("mid_rst_wave", bus.wave_o, 0);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_quiet", bus.valid_o, 0);
    step(20);

    for (int it = 0; it < 30; it++) begin
      bus.div_i = DW'($urandom_range(0, 5));
      bus.amp_i = GW'($urandom);
      load(PW'($urandom));
      bus.en_i        = ($urandom_range(0, 3) != 0);
      bus.phase_clr_i = ($urandom_range(0, 7) == 0);
      step(1);
      bus.phase_clr_i = 1'b0;
      step($urandom_range(5, 40));
      bus.en_i = 1'b1;
      step($urandom_range(5, 20));
    end

    bus.en_i = 1'b0;
    step(10);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
